// File: rtl/job_dispatcher_if.sv
// Handshake and memory-port bundle between the job dispatcher and its environment.
// The dispatcher drives the out_* signals through the master modport.
interface job_dispatcher_if #(
    parameter int cell_width      = 32,
    parameter int index_width     = 8,
    parameter int width           = 96,
    parameter int memory_size_log = 8
);
    logic                       in_start;
    logic [width-1:0]           in_mem_data;
    logic                       in_index_ack;
    logic                       in_result_ready;
    logic                       out_mem_read_en;
    logic [memory_size_log-1:0] out_mem_address;
    logic                       out_grant;
    logic [index_width-1:0]     out_row_index;
    logic [index_width-1:0]     out_col_index;
    logic [index_width-1:0]     out_mu;
    logic                       out_index_ready;
    logic [cell_width-1:0]      out_config;
    logic [2*index_width-1:0]   out_job_count;
    logic                       out_busy;
    logic                       out_done;

    modport master (
        input  in_start, in_mem_data, in_index_ack, in_result_ready,
        output out_mem_read_en, out_mem_address, out_grant, out_row_index,
               out_col_index, out_mu, out_index_ready, out_config,
               out_job_count, out_busy, out_done
    );

    modport slave (
        output in_start, in_mem_data, in_index_ack, in_result_ready,
        input  out_mem_read_en, out_mem_address, out_grant, out_row_index,
               out_col_index, out_mu, out_index_ready, out_config,
               out_job_count, out_busy, out_done
    );
endinterface

// File: rtl/job_dispatcher.sv
// Fetches the config word, then issues every (row, col) index job to the processor
// in row-major order, handing the memory port over for the job phase.
module job_dispatcher #(
    parameter int cell_width      = 32,
    parameter int index_width     = 8,
    parameter int width           = 96,
    parameter int memory_size_log = 8,
    parameter int config_address  = 0
) (
    input logic             in_clk,
    input logic             in_reset,
    job_dispatcher_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, FETCH_REQ, FETCH_WAIT, CHECK, ISSUE, RELEASE, ADVANCE, DONE
    } state_t;

    localparam logic [index_width-1:0]   one_index = 1;
    localparam logic [2*index_width-1:0] one_count = 1;

    state_t                 state;
    logic [index_width-1:0] gamma;
    logic [index_width-1:0] lambda;
    logic [cell_width-1:0]  config_word;
    logic                   last_col;
    logic                   last_row;
    logic                   unused_inputs;

    assign config_word = bus.in_mem_data[cell_width-1:0];
    assign last_col    = (bus.out_col_index == gamma - one_index);
    assign last_row    = (bus.out_row_index == lambda - one_index);

    // The ack is informational only, and the upper memory cells never matter here.
    assign unused_inputs = ^{bus.in_index_ack, bus.in_mem_data[width-1:cell_width]};

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state               <= IDLE;
            gamma               <= '0;
            lambda              <= '0;
            bus.out_mem_read_en <= 1'b0;
            bus.out_mem_address <= '0;
            bus.out_grant       <= 1'b0;
            bus.out_row_index   <= '0;
            bus.out_col_index   <= '0;
            bus.out_mu          <= '0;
            bus.out_index_ready <= 1'b0;
            bus.out_config      <= '0;
            bus.out_job_count   <= '0;
            bus.out_busy        <= 1'b0;
            bus.out_done        <= 1'b0;
        end else begin
            bus.out_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_start) begin
                        state               <= FETCH_REQ;
                        bus.out_busy        <= 1'b1;
                        bus.out_mem_read_en <= 1'b1;
                        bus.out_mem_address <= memory_size_log'(config_address);
                        bus.out_job_count   <= '0;
                        bus.out_row_index   <= '0;
                        bus.out_col_index   <= '0;
                    end
                end
                FETCH_REQ: begin
                    state <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    state               <= CHECK;
                    bus.out_mem_read_en <= 1'b0;
                    bus.out_config      <= config_word;
                    bus.out_mu          <= config_word[16 +: index_width];
                    gamma               <= config_word[8 +: index_width];
                    lambda              <= config_word[0 +: index_width];
                end
                CHECK: begin
                    if (gamma == '0 || lambda == '0) begin
                        state        <= DONE;
                        bus.out_done <= 1'b1;
                    end else begin
                        state               <= ISSUE;
                        bus.out_grant       <= 1'b1;
                        bus.out_index_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.in_result_ready) begin
                        state               <= RELEASE;
                        bus.out_index_ready <= 1'b0;
                    end
                end
                // Waiting for result_ready to fall keeps a lingering result from closing the next job.
                RELEASE: begin
                    if (!bus.in_result_ready) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    bus.out_job_count <= bus.out_job_count + one_count;
                    if (last_col && last_row) begin
                        state         <= DONE;
                        bus.out_grant <= 1'b0;
                        bus.out_done  <= 1'b1;
                    end else begin
                        state               <= ISSUE;
                        bus.out_index_ready <= 1'b1;
                        if (last_col) begin
                            bus.out_col_index <= '0;
                            bus.out_row_index <= bus.out_row_index + one_index;
                        end else begin
                            bus.out_col_index <= bus.out_col_index + one_index;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.out_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_job_dispatcher.sv
// Self-checking bench: memory and processor models around job_dispatcher, with the
// expected job sequence built independently from gamma/lambda by nested loops.
module tb_job_dispatcher;

    localparam int cell_width      = 32;
    localparam int index_width     = 8;
    localparam int width           = 96;
    localparam int memory_size_log = 8;
    localparam int config_address  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    job_dispatcher_if #(
        .cell_width(cell_width), .index_width(index_width),
        .width(width), .memory_size_log(memory_size_log)
    ) bus ();

    job_dispatcher #(
        .cell_width(cell_width), .index_width(index_width), .width(width),
        .memory_size_log(memory_size_log), .config_address(config_address)
    ) dut (
        .in_clk(clk),
        .in_reset(rst_n),
        .bus(bus)
    );

    logic [width-1:0] mem [0:255];
    int checks = 0;
    int errors = 0;
    int resp_delay = 4;
    int resp_hold  = 1;

    int done_cnt, fetch_cnt, stable_err, overlap_err, mu_err, stale_err;
    logic grant_seen;
    logic [15:0] job_q[$];
    logic prev_ready, prev_rd;
    logic [23:0] prev_rcm;
    logic [7:0] exp_mu;

    // Registered memory: data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (bus.out_mem_read_en) bus.in_mem_data <= mem[bus.out_mem_address];
    end

    // Processor model: result_ready after resp_delay cycles, held for resp_hold cycles.
    initial begin : processor_model
        int wait_cnt;
        int hold_cnt;
        wait_cnt = 0;
        hold_cnt = 0;
        bus.in_index_ack    = 1'b0;
        bus.in_result_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.in_index_ack = 1'b0;
            if (!rst_n) begin
                wait_cnt = 0;
                hold_cnt = 0;
                bus.in_result_ready = 1'b0;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) bus.in_result_ready = 1'b0;
            end else if (bus.out_index_ready) begin
                if (wait_cnt == 0) bus.in_index_ack = 1'b1;
                wait_cnt++;
                if (wait_cnt >= resp_delay) begin
                    bus.in_result_ready = 1'b1;
                    hold_cnt = resp_hold;
                    wait_cnt = 0;
                end
            end
        end
    end

    always begin : monitor
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev_ready = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            if (bus.out_index_ready && !prev_ready)
                job_q.push_back({bus.out_row_index, bus.out_col_index});
            if (bus.out_index_ready && prev_ready &&
                ({bus.out_row_index, bus.out_col_index, bus.out_mu} != prev_rcm))
                stable_err++;
            if (bus.out_index_ready && bus.out_mu != exp_mu) mu_err++;
            if (bus.out_index_ready && bus.in_result_ready) stale_err++;
            if (bus.out_grant && bus.out_mem_read_en) overlap_err++;
            if (bus.out_done) done_cnt++;
            if (bus.out_mem_read_en && !prev_rd) fetch_cnt++;
            if (bus.out_grant) grant_seen = 1'b1;
            prev_ready = bus.out_index_ready;
            prev_rd    = bus.out_mem_read_en;
            prev_rcm   = {bus.out_row_index, bus.out_col_index, bus.out_mu};
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_monitor();
        done_cnt = 0; fetch_cnt = 0; stable_err = 0; overlap_err = 0;
        mu_err = 0; stale_err = 0; grant_seen = 1'b0;
        job_q.delete();
    endtask

    task automatic apply_stimulus(input logic [31:0] cfg, input int delay, input int hold,
                                  input bit poke, input bit latency_check);
        logic [15:0] exp_q[$];
        int gamma_v, lambda_v, budget;
        bit zero, finished, poked;
        gamma_v  = int'(cfg[15:8]);
        lambda_v = int'(cfg[7:0]);
        zero     = (gamma_v == 0) || (lambda_v == 0);
        finished = 1'b0;
        poked    = 1'b0;
        for (int r = 0; r < lambda_v; r++)
            for (int c = 0; c < gamma_v; c++)
                exp_q.push_back({8'(r), 8'(c)});
        mem[config_address] = {$urandom, $urandom, cfg};
        resp_delay = delay;
        resp_hold  = hold;
        exp_mu     = cfg[23:16];
        clear_monitor();
        $display("[TB] sweep cfg=%08h delay=%0d hold=%0d poke=%0d", cfg, delay, hold, poke);
        @(negedge clk);
        bus.in_start = 1'b1;
        if (latency_check) begin
            @(negedge clk);
            bus.in_start = 1'b0;
            check_output("lat_read_c1", bus.out_mem_read_en, 1);
            check_output("lat_grant_c1", bus.out_grant, 0);
            check_output("lat_busy_c1", bus.out_busy, 1);
            @(negedge clk);
            check_output("lat_read_c2", bus.out_mem_read_en, 1);
            @(negedge clk);
            check_output("lat_read_c3", bus.out_mem_read_en, 0);
            check_output("lat_config", bus.out_config, cfg);
            check_output("lat_ready_c3", bus.out_index_ready, 0);
            check_output("lat_done_c3", bus.out_done, 0);
            @(negedge clk);
            check_output("lat_ready_c4", bus.out_index_ready, !zero);
            check_output("lat_grant_c4", bus.out_grant, !zero);
            check_output("lat_done_c4", bus.out_done, zero);
            finished = bus.out_done;
        end
        budget = exp_q.size() * (delay + hold + 6) + 20;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            bus.in_start = 1'b0;
            if (bus.out_done) finished = 1'b1;
            if (poke && (bus.out_done || (bus.out_index_ready && !poked))) begin
                bus.in_start = 1'b1;
                poked = 1'b1;
            end
        end
        @(negedge clk);
        bus.in_start = 1'b0;
        repeat (4) @(negedge clk);
        check_output("done_timeout", finished, 1);
        check_output("job_count", bus.out_job_count, exp_q.size());
        check_output("jobs_issued", job_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < job_q.size(); i++)
            check_output($sformatf("job_%0d", i), job_q[i], exp_q[i]);
        check_output("done_pulses", done_cnt, 1);
        check_output("fetch_count", fetch_cnt, 1);
        check_output("busy_after", bus.out_busy, 0);
        check_output("grant_after", bus.out_grant, 0);
        check_output("grant_seen", grant_seen, !zero);
        check_output("config_kept", bus.out_config, cfg);
        check_output("mu_out", bus.out_mu, cfg[23:16]);
        check_output("index_stable", stable_err, 0);
        check_output("mu_during_jobs", mu_err, 0);
        check_output("ready_with_result", stale_err, 0);
        check_output("grant_read_overlap", overlap_err, 0);
    endtask

    initial begin
        bit found;
        logic [31:0] rcfg;
        bus.in_start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
        exp_mu = 8'h00;
        clear_monitor();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_flags", {bus.out_busy, bus.out_index_ready, bus.out_grant,
                                     bus.out_mem_read_en, bus.out_done}, 0);
        check_output("reset_count", bus.out_job_count, 0);
        check_output("reset_config", bus.out_config, 0);
        check_output("reset_address", bus.out_mem_address, 0);
        rst_n = 1'b1;

        apply_stimulus(32'h00050203, 4, 1, 1'b0, 1'b1);
        apply_stimulus(32'h00070300, 4, 1, 1'b0, 1'b1);
        apply_stimulus(32'hA5090004, 2, 1, 1'b0, 1'b0);
        apply_stimulus(32'h00050203, 2, 5, 1'b0, 0);

        $display("[TB] reset during job (1,0)");
        mem[config_address] = {$urandom, $urandom, 32'h00050203};
        resp_delay = 4;
        resp_hold  = 1;
        exp_mu     = 8'h05;
        clear_monitor();
        @(negedge clk);
        bus.in_start = 1'b1;
        @(negedge clk);
        bus.in_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus.out_index_ready && bus.out_row_index == 8'd1 && bus.out_col_index == 8'd0)
                found = 1'b1;
        end
        check_output("reach_job_1_0", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_ready", bus.out_index_ready, 0);
        check_output("async_grant", bus.out_grant, 0);
        check_output("async_all", {bus.out_busy, bus.out_mem_read_en, bus.out_done,
                                   bus.out_row_index, bus.out_col_index, bus.out_mu,
                                   bus.out_job_count, bus.out_config}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(32'h00050203, 4, 1, 1'b0, 1'b0);

        apply_stimulus(32'h00040302, 3, 1, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rcfg = {8'($urandom), 8'($urandom), 8'($urandom_range(1, 5)),
                    8'($urandom_range(1, 5))};
            apply_stimulus(rcfg, $urandom_range(1, 4), $urandom_range(1, 3), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/job_dispatcher.md
Name: job_dispatcher

Overview:
- Upstream sequencer for the matrix coprocessor `processor`. It fetches the configuration word from shared memory and latches mu, gamma and lambda.
- It then walks every (row, col) output index in row-major order and issues one index job at a time to the processor over the index_ready/result_ready handshake.
- It owns the memory port only during the config fetch. It hands the port to the processor via out_grant for the job phase.

Parameters:
- cell_width, 32, width of one memory cell and of the config word
- index_width, 8, width of the row, col and mu indices
- width, 96, memory data bus width (cell_width * size)
- memory_size_log, 8, memory address width
- config_address, 0, memory address of the config word

Ports:
- in_clk  input  1  clock; all state changes on the rising edge
- in_reset  input  1  asynchronous, active-low reset
- in_start  input  1  start request; sampled only in IDLE
- in_mem_data  input  width  memory read data; registered memory, valid the cycle after a read
- in_index_ack  input  1  processor has captured the current index
- in_result_ready  input  1  processor has finished the current index
- out_mem_read_en  output  1  dispatcher memory read strobe (config fetch only)
- out_mem_address  output  memory_size_log  dispatcher memory address
- out_grant  output  1  memory port belongs to the processor; the external mux selects on this
- out_row_index  output  index_width  current row
- out_col_index  output  index_width  current column
- out_mu  output  index_width  mu from the config word
- out_index_ready  output  1  job valid to the processor
- out_config  output  cell_width  captured config word
- out_job_count  output  2*index_width  number of completed jobs
- out_busy  output  1  high in every state except IDLE
- out_done  output  1  one-cycle pulse when the sweep ends

Behaviour:
- Reset (async, in_reset=0): state IDLE; every output 0; all counters and registers 0. Reset mid-operation aborts immediately, with out_index_ready and out_grant dropping asynchronously.
- All outputs are registered. Config fields: mu=[23:16], gamma=[15:8], lambda=[7:0]. Bits [cell_width-1:24] are ignored but kept in out_config.
- FSM states: IDLE, FETCH_REQ, FETCH_WAIT, CHECK, ISSUE, RELEASE, ADVANCE, DONE.
- IDLE:
  - in_start=1 -> FETCH_REQ.
  - On this transition, clear out_job_count and load row=0, col=0.
- FETCH_REQ: out_mem_read_en=1, out_mem_address=config_address, out_grant=0 -> FETCH_WAIT.
- FETCH_WAIT:
  - Read strobe held.
  - At the edge leaving this state, capture in_mem_data[cell_width-1:0] into out_config/mu/gamma/lambda, then drop out_mem_read_en -> CHECK.
- CHECK:
  - gamma==0 or lambda==0 -> DONE (zero jobs issued, out_grant stays 0).
  - Otherwise -> ISSUE with out_grant=1 and out_index_ready=1.
- ISSUE:
  - Hold out_index_ready, row, col and mu stable until in_result_ready is sampled 1 -> RELEASE (out_index_ready=0).
  - in_index_ack is monitored only; it does not advance the FSM.
- RELEASE:
  - Wait until in_result_ready is sampled 0 -> ADVANCE.
  - This guarantees at least one cycle with index_ready low and prevents a stale result_ready from completing the next job.
- ADVANCE:
  - out_job_count +1.
  - If col==gamma-1 and row==lambda-1 -> DONE.
  - Else if col==gamma-1 -> col=0, row+1 -> ISSUE.
  - Else col+1 -> ISSUE.
  - out_index_ready is re-asserted on entry to ISSUE.
- DONE: out_grant=0, out_done=1 for exactly one cycle -> IDLE.
- Latency: start sampled at edge 0 -> read strobe after edge 0 -> config captured at edge 2 -> first out_index_ready high after edge 3.
- in_start outside IDLE is ignored. A simultaneous in_start with the DONE->IDLE transition is also ignored; a new start needs a fresh sample in IDLE.
- out_grant is high from ISSUE entry through the last ADVANCE. It is never high while out_mem_read_en is high.
- Counters never wrap within a legal sweep. The maximum job count is 255*255, which fits in 2*index_width bits.

Test Plan:
- Config 0x00050203 at address 0, processor model responds with result_ready 4 cycles after index_ready -> jobs issued in order (0,0),(0,1),(1,0),(1,1),(2,0),(2,1); out_mu=5 throughout; out_job_count=6; single out_done pulse; out_grant=0 after DONE.
- Latency check with the same config -> out_mem_read_en high during cycles 1-2 after start; out_config=0x00050203 after edge 2; first out_index_ready high after edge 3.
- Config 0x00070300 (lambda=0) -> no index_ready ever asserted, out_grant stays 0, out_job_count=0, out_done pulses 3 cycles after start.
- Processor holds result_ready high for 5 cycles after each job -> each next index_ready asserts only after result_ready falls; no job is counted twice; final count=gamma*lambda.
- Reset pulled low while in ISSUE on job (1,0) -> all outputs 0 asynchronously; after release and a new start, the config is re-fetched and the sweep restarts at (0,0) with count 0.
- in_start pulsed during ISSUE and in the DONE cycle -> ignored; the sweep completes once with no second fetch.
